// File: rtl/cu_edge_data_write_arbiter_pkg.sv
// Shared types and defaults for the compute-unit edge-data write arbiter.
package cu_edge_data_write_arbiter_pkg;

  localparam int EDGE_WRITE_ARB_NUM_REQ    = 4;
  localparam int EDGE_WRITE_ARB_FIFO_DEPTH = 4;

  localparam int EDGE_INDEX_W = 32;
  localparam int EDGE_DATA_W  = 64;
  localparam int CU_ID_W      = 8;

  // One edge-data write request as produced by a producer and consumed by
  // the edge-data write control stage.
  typedef struct packed {
    logic                    valid;
    logic [EDGE_INDEX_W-1:0] index;
    logic [EDGE_DATA_W-1:0]  data;
    logic [CU_ID_W-1:0]      cu_id;
  } EdgeDataWrite;

  // Arbiter operating mode.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } ARB_STATE;

  // Turn a buffered entry into the form driven on the write path.
  function automatic EdgeDataWrite edge_write_grant(input EdgeDataWrite entry);
    EdgeDataWrite w;
    w       = entry;
    w.valid = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/cu_edge_data_write_arbiter_fifo.sv
// Per-requester synchronous FIFO holding buffered edge-data writes.
// Pointers carry one extra MSB so full and empty are distinguishable.
module cu_edge_data_write_fifo
  import cu_edge_data_write_arbiter_pkg::*;
#(
  parameter int DEPTH = EDGE_WRITE_ARB_FIFO_DEPTH
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         push_in,
  input  logic         pop_in,
  input  EdgeDataWrite wdata_in,
  output EdgeDataWrite rdata_out,
  output logic         empty_out,
  output logic         full_out,
  output logic         almost_full_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  EdgeDataWrite  mem_q [DEPTH];
  EdgeDataWrite  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_s;
  logic [PW-1:0] count_next_s;
  logic          almost_full_q, almost_full_d;
  logic          do_push_s, do_pop_s;

  assign count_s         = wptr_q - rptr_q;
  assign empty_out       = (wptr_q == rptr_q);
  assign full_out        = (count_s == PW'(DEPTH));
  assign rdata_out       = mem_q[rptr_q[AW-1:0]];
  assign almost_full_out = almost_full_q;

  // Next storage/pointer values; almost-full follows the post-edge occupancy.
  always_comb begin
    mem_d     = mem_q;
    do_push_s = push_in && !full_out;
    do_pop_s  = pop_in && !empty_out;
    if (do_push_s) begin
      mem_d[wptr_q[AW-1:0]] = wdata_in;
      wptr_d                = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    count_next_s  = wptr_d - rptr_d;
    almost_full_d = (count_next_s >= PW'(DEPTH - 1));
  end

  // FIFO state registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q        <= '0;
      rptr_q        <= '0;
      almost_full_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      almost_full_q <= almost_full_d;
    end
  end

endmodule

// File: rtl/cu_edge_data_write_arbiter.sv
// Round-robin arbiter sharing the edge-data write path among NUM_REQ
// producers, each buffered by its own small FIFO.
module cu_edge_data_write_arbiter
  import cu_edge_data_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = EDGE_WRITE_ARB_NUM_REQ,
  parameter int FIFO_DEPTH = EDGE_WRITE_ARB_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  EdgeDataWrite               edge_data_write_in [NUM_REQ],
  input  logic                       write_buffer_full_in,
  output EdgeDataWrite               edge_data_write_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       req_almost_full_out [NUM_REQ],
  output logic                       overflow_out,
  output logic [31:0]                write_count_out
);

  localparam int IW = $clog2(NUM_REQ);

  // Rotating priority search: first ready requester after 'last', wrapping.
  // Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] ready,
                                          input logic [IW-1:0]      last);
    logic          found;
    logic          hit;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand  = last + IW'(k);
      hit   = ready[cand] & ~found;
      idx   = hit ? cand : idx;
      found = found | hit;
    end
    return {found, idx};
  endfunction

  logic         enabled_q, enabled_d;
  ARB_STATE     state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  EdgeDataWrite out_q, out_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  count_q, count_d;

  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] pop_s;
  logic [NUM_REQ-1:0] fifo_empty_s;
  logic [NUM_REQ-1:0] fifo_full_s;
  EdgeDataWrite       fifo_head_s [NUM_REQ];
  logic [IW:0]        pick_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    cu_edge_data_write_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clock           (clock),
      .rstn            (rstn),
      .push_in         (push_s[g]),
      .pop_in          (pop_s[g]),
      .wdata_in        (edge_data_write_in[g]),
      .rdata_out       (fifo_head_s[g]),
      .empty_out       (fifo_empty_s[g]),
      .full_out        (fifo_full_s[g]),
      .almost_full_out (req_almost_full_out[g])
    );
  end

  assign edge_data_write_out = out_q;
  assign grant_id_out        = grant_id_q;
  assign overflow_out        = overflow_q;
  assign write_count_out     = count_q;

  // Mode for the current cycle: follows the registered enable and the live
  // back-pressure input, so ARB/STALL switch without a cycle of lag.
  always_comb begin
    enabled_d = enabled_in;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enabled_q) begin
          state_d = write_buffer_full_in ? ST_STALL : ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB, ST_STALL: begin
        if (!enabled_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = write_buffer_full_in ? ST_STALL : ST_ARB;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Push admission, overflow capture and the round-robin grant.
  always_comb begin
    push_s       = '0;
    pop_s        = '0;
    overflow_d   = overflow_q;
    out_d        = '0;
    grant_id_d   = '0;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    pick_s       = rr_pick(~fifo_empty_s, last_grant_q);

    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_d != ST_IDLE) && edge_data_write_in[i].valid) begin
        push_s[i]  = ~fifo_full_s[i];
        overflow_d = overflow_d | fifo_full_s[i];
      end else begin
        push_s[i] = 1'b0;
      end
    end

    if ((state_d == ST_ARB) && pick_s[IW]) begin
      pop_s[pick_s[IW-1:0]] = 1'b1;
      out_d                 = edge_write_grant(fifo_head_s[pick_s[IW-1:0]]);
      grant_id_d            = pick_s[IW-1:0];
      last_grant_d          = pick_s[IW-1:0];
      count_d               = count_q + 32'd1;
    end else begin
      out_d        = '0;
      grant_id_d   = '0;
      last_grant_d = last_grant_q;
      count_d      = count_q;
    end
  end

  // Control and output registers; last_grant resets so requester 0 goes first.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q    <= 1'b0;
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      out_q        <= '0;
      grant_id_q   <= '0;
      overflow_q   <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      enabled_q    <= enabled_d;
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_q        <= out_d;
      grant_id_q   <= grant_id_d;
      overflow_q   <= overflow_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_cu_edge_data_write_arbiter.sv
// Self-checking bench for cu_edge_data_write_arbiter with a queue-based
// reference model of the request FIFOs and round-robin grant rule.
module tb_cu_edge_data_write_arbiter;
  import cu_edge_data_write_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_DEPTH = 4;

  logic         clock;
  logic         rstn;
  logic         en_in;
  EdgeDataWrite req [NUM_REQ];
  logic         wbf;
  EdgeDataWrite edge_data_write_out;
  logic [1:0]   grant_id_out;
  logic         af [NUM_REQ];
  logic         overflow_out;
  logic [31:0]  write_count_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  EdgeDataWrite q [NUM_REQ][$];
  int           last_m;
  bit           en_m;
  int unsigned  cnt_m;
  bit           ovf_m;
  EdgeDataWrite exp_out;
  logic [1:0]   exp_gid;
  bit           exp_af [NUM_REQ];

  cu_edge_data_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock                (clock),
    .rstn                 (rstn),
    .enabled_in           (en_in),
    .edge_data_write_in   (req),
    .write_buffer_full_in (wbf),
    .edge_data_write_out  (edge_data_write_out),
    .grant_id_out         (grant_id_out),
    .req_almost_full_out  (af),
    .overflow_out         (overflow_out),
    .write_count_out      (write_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic EdgeDataWrite mk(input logic [31:0] idx, input logic [63:0] d,
                                      input logic [7:0] c);
    EdgeDataWrite w;
    w       = '0;
    w.valid = 1'b1;
    w.index = idx;
    w.data  = d;
    w.cu_id = c;
    return w;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) req[i] = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      q[i].delete();
      exp_af[i] = 1'b0;
    end
    last_m  = NUM_REQ - 1;
    en_m    = 1'b0;
    cnt_m   = 0;
    ovf_m   = 1'b0;
    exp_out = '0;
    exp_gid = 2'd0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at it.
  task automatic tick();
    EdgeDataWrite o;
    int g;
    bit full_pre [NUM_REQ];
    o = '0;
    g = -1;
    for (int i = 0; i < NUM_REQ; i++) full_pre[i] = (q[i].size() == FIFO_DEPTH);
    if (en_m && !wbf) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int j;
        j = (last_m + k) % NUM_REQ;
        if (g < 0 && q[j].size() > 0) g = j;
      end
    end
    if (g >= 0) begin
      o       = q[g].pop_front();
      o.valid = 1'b1;
      last_m  = g;
      cnt_m   = cnt_m + 1;
    end
    if (en_m) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i].valid) begin
          if (full_pre[i]) ovf_m = 1'b1;
          else q[i].push_back(req[i]);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) exp_af[i] = (q[i].size() >= FIFO_DEPTH - 1);
    exp_out = o;
    exp_gid = (g >= 0) ? 2'(g) : 2'd0;
    en_m    = en_in;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_reqs();
    en_in = 1'b0;
    wbf   = 1'b0;
    @(posedge clock);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en_in = 1'b0;
    wbf   = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (edge_data_write_out !== '0 || grant_id_out !== 2'd0 || overflow_out !== 1'b0 ||
        write_count_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: out=%h gid=%0d ovf=%b cnt=%0d expected all 0",
               edge_data_write_out, grant_id_out, overflow_out, write_count_out);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (af[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_af[%0d]: got %b expected 0", i, af[i]);
      end
    end
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_single();
    en_in = 1'b1;
    tick();
    req[2] = mk(32'h10, 64'hAB, 8'd2);
    tick();
    clear_reqs();
    checks++;
    if (edge_data_write_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: valid=%b expected 0 one cycle after push",
               edge_data_write_out.valid);
    end
    tick();
    checks++;
    if (edge_data_write_out.valid !== 1'b1 || edge_data_write_out.index !== 32'h10 ||
        edge_data_write_out.data !== 64'hAB || grant_id_out !== 2'd2) begin
      failures++;
      $display("FAIL single_grant: valid=%b index=%h data=%h gid=%0d expected 1/10/ab/2",
               edge_data_write_out.valid, edge_data_write_out.index,
               edge_data_write_out.data, grant_id_out);
    end
    checks++;
    if (write_count_out !== 32'd1) begin
      failures++;
      $display("FAIL single_count: got %0d expected 1", write_count_out);
    end
  endtask

  task automatic test_fairness();
    int k;
    apply_reset();
    en_in = 1'b1;
    tick();
    k = 0;
    for (int t = 0; t < 13; t++) begin
      if (t < 3) begin
        for (int i = 0; i < NUM_REQ; i++)
          req[i] = mk(32'h100 * i + t, {$urandom, $urandom}, 8'(i));
      end else begin
        clear_reqs();
      end
      tick();
      if (t >= 1) begin
        checks++;
        if (edge_data_write_out.valid !== 1'b1 || grant_id_out !== 2'(k % 4) ||
            edge_data_write_out.index !== 32'(32'h100 * (k % 4) + k / 4) ||
            edge_data_write_out !== exp_out) begin
          failures++;
          $display("FAIL fairness_grant%0d: valid=%b gid=%0d index=%h expected gid %0d index %h",
                   k, edge_data_write_out.valid, grant_id_out, edge_data_write_out.index,
                   k % 4, 32'h100 * (k % 4) + k / 4);
        end
        k++;
      end
    end
    checks++;
    if (write_count_out !== 32'd12) begin
      failures++;
      $display("FAIL fairness_count: got %0d expected 12", write_count_out);
    end
    tick();
    checks++;
    if (edge_data_write_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL fairness_drained: valid=%b expected 0", edge_data_write_out.valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    en_in = 1'b1;
    tick();
    wbf = 1'b1;
    for (int n = 0; n < 5; n++) begin
      req[1] = mk(32'h20 + n, {$urandom, $urandom}, 8'd1);
      tick();
      checks++;
      if (edge_data_write_out.valid !== 1'b0 || af[1] !== (n >= 2) ||
          overflow_out !== (n == 4)) begin
        failures++;
        $display("FAIL bp_push%0d: valid=%b af1=%b ovf=%b expected 0/%b/%b",
                 n, edge_data_write_out.valid, af[1], overflow_out, n >= 2, n == 4);
      end
    end
    clear_reqs();
    wbf = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (edge_data_write_out.valid !== 1'b1 || edge_data_write_out.index !== 32'h20 + n ||
          grant_id_out !== 2'd1 || af[1] !== exp_af[1]) begin
        failures++;
        $display("FAIL bp_drain%0d: valid=%b index=%h gid=%0d af1=%b expected 1/%h/1/%b",
                 n, edge_data_write_out.valid, edge_data_write_out.index, grant_id_out,
                 af[1], 32'h20 + n, exp_af[1]);
      end
    end
    tick();
    checks++;
    if (edge_data_write_out.valid !== 1'b0 || overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_after: valid=%b ovf=%b expected 0/1",
               edge_data_write_out.valid, overflow_out);
    end
  endtask

  task automatic test_enable_toggle();
    logic [31:0] exp_idx [7];
    apply_reset();
    en_in = 1'b1;
    tick();
    wbf = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req[3] = mk(32'h30 + n, {$urandom, $urandom}, 8'd3);
      tick();
    end
    clear_reqs();
    en_in = 1'b0;
    wbf   = 1'b0;
    // grant still issues on the edge where the enable falls, then stops
    exp_idx = '{32'h30, 32'h0, 32'h0, 32'h0, 32'h0, 32'h31, 32'h32};
    for (int t = 0; t < 7; t++) begin
      if (t >= 1 && t <= 3) req[3] = mk(32'h3F, 64'h0, 8'd3);
      else clear_reqs();
      if (t == 4) en_in = 1'b1;
      tick();
      checks++;
      if (edge_data_write_out.valid !== (exp_idx[t] != 32'h0) ||
          (exp_idx[t] != 32'h0 && edge_data_write_out.index !== exp_idx[t]) ||
          edge_data_write_out !== exp_out) begin
        failures++;
        $display("FAIL enable_toggle_t%0d: valid=%b index=%h expected index %h",
                 t, edge_data_write_out.valid, edge_data_write_out.index, exp_idx[t]);
      end
    end
    tick();
    checks++;
    if (edge_data_write_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL enable_toggle_ignored: valid=%b expected 0", edge_data_write_out.valid);
    end
  endtask

  task automatic test_wraparound();
    apply_reset();
    en_in = 1'b1;
    tick();
    for (int t = 0; t < 2 * FIFO_DEPTH + 2; t++) begin
      if (t < 2 * FIFO_DEPTH + 1) req[0] = mk(32'h40 + t, {$urandom, $urandom}, 8'd0);
      else clear_reqs();
      tick();
      if (t >= 1) begin
        checks++;
        if (edge_data_write_out.valid !== 1'b1 || edge_data_write_out.index !== 32'h40 + t - 1 ||
            edge_data_write_out !== exp_out) begin
          failures++;
          $display("FAIL wrap_order%0d: valid=%b index=%h expected %h",
                   t, edge_data_write_out.valid, edge_data_write_out.index, 32'h40 + t - 1);
        end
      end
    end
    checks++;
    if (overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL wrap_overflow: got %b expected 0", overflow_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en_in = ($urandom_range(0, 9) != 0);
      wbf   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 99) < 40)
          req[i] = mk($urandom, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        else
          req[i] = '0;
      end
      tick();
      checks++;
      if (edge_data_write_out !== exp_out || grant_id_out !== exp_gid) begin
        failures++;
        $display("FAIL rand_out c%0d: got %h gid %0d expected %h gid %0d",
                 c, edge_data_write_out, grant_id_out, exp_out, exp_gid);
      end
      checks++;
      if (overflow_out !== ovf_m || write_count_out !== cnt_m) begin
        failures++;
        $display("FAIL rand_status c%0d: ovf=%b cnt=%0d expected %b/%0d",
                 c, overflow_out, write_count_out, ovf_m, cnt_m);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        checks++;
        if (af[i] !== exp_af[i]) begin
          failures++;
          $display("FAIL rand_af c%0d req%0d: got %b expected %b", c, i, af[i], exp_af[i]);
        end
      end
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    en_in = 1'b1;
    wbf   = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NUM_REQ; i++) req[i] = mk(32'h50 + t, 64'h0, 8'(i));
      wbf = (t < 2);
      tick();
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (edge_data_write_out !== '0 || grant_id_out !== 2'd0 || overflow_out !== 1'b0 ||
        write_count_out !== 32'd0 || af[0] !== 1'b0 || af[3] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: out=%h gid=%0d ovf=%b cnt=%0d af0=%b af3=%b",
               edge_data_write_out, grant_id_out, overflow_out, write_count_out, af[0], af[3]);
    end
    @(posedge clock);
    #1;
    rstn = 1'b1;
    model_reset();
    clear_reqs();
    wbf   = 1'b0;
    en_in = 1'b1;
    tick();
    for (int i = 0; i < NUM_REQ; i++) req[i] = mk(32'h60 + i, 64'h0, 8'(i));
    tick();
    clear_reqs();
    tick();
    checks++;
    if (edge_data_write_out.valid !== 1'b1 || grant_id_out !== 2'd0 ||
        edge_data_write_out.index !== 32'h60) begin
      failures++;
      $display("FAIL reset_mid_first: valid=%b gid=%0d index=%h expected 1/0/60",
               edge_data_write_out.valid, grant_id_out, edge_data_write_out.index);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_enable_toggle();
    test_wraparound();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
